// File: rtl/car_lane_engine_pkg.sv
// rtl/car_lane_engine_pkg.sv - shared defaults, sprite size and command priority for the car lane engine
package car_lane_engine_pkg;

  localparam int X_W_DEF   = 10;
  localparam int Y_W_DEF   = 9;
  localparam int Y_MAX_DEF = 479;

  // Car sprite footprint used by the optional collision comparators
  localparam int CAR_W = 32;
  localparam int CAR_H = 48;

  // Per-slot command, ordered by increasing priority
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_TICK,
    CMD_LOAD,
    CMD_JUMP
  } cmdT;

  // Resolve the commands hitting one slot into the single winning action
  function automatic cmdT selectCmd(input logic jumpHit, input logic loadHit, input logic tick);
    if (jumpHit)      return CMD_JUMP;
    else if (loadHit) return CMD_LOAD;
    else if (tick)    return CMD_TICK;
    else              return CMD_NONE;
  endfunction

endpackage

// File: rtl/car_lane_engine_if.sv
// rtl/car_lane_engine_if.sv - command/position bundle between game control and the car lane engine (COLLISION_DETECT_EN adds player/collision signals)
interface car_lane_engine_if #(
  parameter int N_CARS = 4,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int IDX_W  = 2
);

  logic                    iLoad;
  logic [IDX_W-1:0]        iLoadIdx;
  logic [X_W-1:0]          iPosX;
  logic [Y_W-1:0]          iPosY;
  logic                    iJump;
  logic [IDX_W-1:0]        iJumpIdx;
  logic [X_W-1:0]          iAuxX;
  logic [Y_W-1:0]          iAuxY;
  logic                    iTick;
  logic [N_CARS*X_W-1:0]   oPosX;
  logic [N_CARS*Y_W-1:0]   oPosY;
  logic [N_CARS-1:0]       oActive;
  logic [N_CARS-1:0]       oExit;
`ifdef COLLISION_DETECT_EN
  logic [X_W-1:0]          iPlayerX;
  logic [Y_W-1:0]          iPlayerY;
  logic [N_CARS-1:0]       oCollision;

  modport master (
    output iLoad, iLoadIdx, iPosX, iPosY, iJump, iJumpIdx, iAuxX, iAuxY, iTick, iPlayerX, iPlayerY,
    input  oPosX, oPosY, oActive, oExit, oCollision
  );

  modport slave (
    input  iLoad, iLoadIdx, iPosX, iPosY, iJump, iJumpIdx, iAuxX, iAuxY, iTick, iPlayerX, iPlayerY,
    output oPosX, oPosY, oActive, oExit, oCollision
  );
`else
  modport master (
    output iLoad, iLoadIdx, iPosX, iPosY, iJump, iJumpIdx, iAuxX, iAuxY, iTick,
    input  oPosX, oPosY, oActive, oExit
  );

  modport slave (
    input  iLoad, iLoadIdx, iPosX, iPosY, iJump, iJumpIdx, iAuxX, iAuxY, iTick,
    output oPosX, oPosY, oActive, oExit
  );
`endif

endinterface

// File: rtl/car_lane_engine_slot.sv
// rtl/car_lane_engine_slot.sv - one car slot: X/Y/active/exit registers behind the jump > load > tick mux
module car_lane_engine_slot
  import car_lane_engine_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int STEP  = 1
) (
  input  logic           iClk,
  input  logic           iReset,
  input  logic           loadHit,
  input  logic           jumpHit,
  input  logic           tick,
  input  logic [X_W-1:0] loadX,
  input  logic [Y_W-1:0] loadY,
  input  logic [X_W-1:0] auxX,
  input  logic [Y_W-1:0] auxY,
  output logic [X_W-1:0] posX,
  output logic [Y_W-1:0] posY,
  output logic           active,
  output logic           exitPulse
);

  // One extra bit so Y + STEP past the field width is seen as off-screen, not wrapped
  localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] Y_STEP  = (Y_W+1)'(STEP);

  cmdT            cmd;
  logic [Y_W:0]   sum;
  logic           loadVisible;
  logic [X_W-1:0] posXNext;
  logic [Y_W-1:0] posYNext;
  logic           activeNext;
  logic           exitNext;

  // Next-state mux: jump beats load beats tick; a load in the same cycle still decides the active flag
  always_comb begin
    cmd         = selectCmd(jumpHit, loadHit, tick);
    sum         = {1'b0, posY} + Y_STEP;
    loadVisible = ({1'b0, loadY} <= Y_LIMIT);
    posXNext    = posX;
    posYNext    = posY;
    activeNext  = active;
    exitNext    = 1'b0;
    case (cmd)
      CMD_JUMP: begin
        posXNext = auxX;
        posYNext = auxY;
        if (loadHit) activeNext = loadVisible;
      end
      CMD_LOAD: begin
        posXNext   = loadX;
        posYNext   = loadY;
        activeNext = loadVisible;
      end
      CMD_TICK: begin
        if (active) begin
          if (sum <= Y_LIMIT) begin
            posYNext = sum[Y_W-1:0];
          end else begin
            activeNext = 1'b0;
            exitNext   = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Slot state register; reset wins over any command in the same cycle
  always_ff @(posedge iClk) begin
    if (iReset) begin
      posX      <= '0;
      posY      <= '0;
      active    <= 1'b0;
      exitPulse <= 1'b0;
    end else begin
      posX      <= posXNext;
      posY      <= posYNext;
      active    <= activeNext;
      exitPulse <= exitNext;
    end
  end

endmodule

// File: rtl/car_lane_engine.sv
// rtl/car_lane_engine.sv - N_CARS car position slots with load/jump/frame advance and exit pulses; COLLISION_DETECT_EN adds registered player collision flags
module car_lane_engine
  import car_lane_engine_pkg::*;
#(
  parameter int N_CARS = 4,
  parameter int X_W    = X_W_DEF,
  parameter int Y_W    = Y_W_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int STEP   = 1,
  parameter int IDX_W  = 2
) (
  input logic              iClk,
  input logic              iReset,
  car_lane_engine_if.slave bus
);

  logic [N_CARS*X_W-1:0] posXFlat;
  logic [N_CARS*Y_W-1:0] posYFlat;
  logic [N_CARS-1:0]     activeFlat;
  logic [N_CARS-1:0]     exitFlat;
  logic [N_CARS-1:0]     loadHit;
  logic [N_CARS-1:0]     jumpHit;

  // Index decode: an index beyond the last slot matches nothing, so the command is dropped
  genvar k;
  generate
    for (k = 0; k < N_CARS; k++) begin : gSlot
      assign loadHit[k] = bus.iLoad && (bus.iLoadIdx == IDX_W'(k));
      assign jumpHit[k] = bus.iJump && (bus.iJumpIdx == IDX_W'(k));

      car_lane_engine_slot #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .Y_MAX (Y_MAX),
        .STEP  (STEP)
      ) uSlot (
        .iClk      (iClk),
        .iReset    (iReset),
        .loadHit   (loadHit[k]),
        .jumpHit   (jumpHit[k]),
        .tick      (bus.iTick),
        .loadX     (bus.iPosX),
        .loadY     (bus.iPosY),
        .auxX      (bus.iAuxX),
        .auxY      (bus.iAuxY),
        .posX      (posXFlat[k*X_W +: X_W]),
        .posY      (posYFlat[k*Y_W +: Y_W]),
        .active    (activeFlat[k]),
        .exitPulse (exitFlat[k])
      );
    end
  endgenerate

  assign bus.oPosX   = posXFlat;
  assign bus.oPosY   = posYFlat;
  assign bus.oActive = activeFlat;
  assign bus.oExit   = exitFlat;

`ifdef COLLISION_DETECT_EN
  logic [N_CARS-1:0] hitNext;
  logic [N_CARS-1:0] collision;
  logic [X_W-1:0]    carX;
  logic [Y_W-1:0]    carY;
  logic [X_W-1:0]    dx;
  logic [Y_W-1:0]    dy;

  // Box overlap test on the registered positions; absolute distance avoids signed math
  always_comb begin
    hitNext = '0;
    carX    = '0;
    carY    = '0;
    dx      = '0;
    dy      = '0;
    for (int s = 0; s < N_CARS; s++) begin
      carX = posXFlat[s*X_W +: X_W];
      carY = posYFlat[s*Y_W +: Y_W];
      dx   = (carX >= bus.iPlayerX) ? (carX - bus.iPlayerX) : (bus.iPlayerX - carX);
      dy   = (carY >= bus.iPlayerY) ? (carY - bus.iPlayerY) : (bus.iPlayerY - carY);
      hitNext[s] = activeFlat[s] && (dx < X_W'(CAR_W)) && (dy < Y_W'(CAR_H));
    end
  end

  // Collision flags land one cycle after the positions they were computed from
  always_ff @(posedge iClk) begin
    if (iReset) collision <= '0;
    else        collision <= hitNext;
  end

  assign bus.oCollision = collision;
`endif

endmodule

// File: tb/tb_car_lane_engine.sv
// tb/tb_car_lane_engine.sv - scoreboard bench for car_lane_engine (4-slot and 3-slot instances)
module tb_car_lane_engine;

  logic clk;
  logic rst;

  car_lane_engine_if #(.N_CARS(4), .X_W(10), .Y_W(9), .IDX_W(2)) ifA ();
  car_lane_engine_if #(.N_CARS(3), .X_W(10), .Y_W(9), .IDX_W(2)) ifB ();

  car_lane_engine #(.N_CARS(4), .X_W(10), .Y_W(9), .Y_MAX(479), .STEP(1), .IDX_W(2)) uDutA (
    .iClk   (clk),
    .iReset (rst),
    .bus    (ifA)
  );

  car_lane_engine #(.N_CARS(3), .X_W(10), .Y_W(9), .Y_MAX(479), .STEP(1), .IDX_W(2)) uDutB (
    .iClk   (clk),
    .iReset (rst),
    .bus    (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    dut;
    int    slot;
    int    x;
    int    y;
    int    act;
    int    ex;
  } expT;

  expT sbq[$];
  int  nChecks = 0;
  int  nErrors = 0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input int dut, input int slot,
                         input int x, input int y, input int act, input int ex);
    expT e;
    e.tag = tag; e.dut = dut; e.slot = slot;
    e.x = x; e.y = y; e.act = act; e.ex = ex;
    sbq.push_back(e);
  endtask

  // Clock one edge, then drain everything expected for that edge
  task automatic cycle();
    expT e;
    int  ox, oy, oa, oe;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        ox = int'(ifA.oPosX[e.slot*10 +: 10]);
        oy = int'(ifA.oPosY[e.slot*9 +: 9]);
        oa = int'(ifA.oActive);
        oe = int'(ifA.oExit);
      end else begin
        ox = int'(ifB.oPosX[e.slot*10 +: 10]);
        oy = int'(ifB.oPosY[e.slot*9 +: 9]);
        oa = int'(ifB.oActive);
        oe = int'(ifB.oExit);
      end
      checkVal({e.tag, "_x"}, ox, e.x);
      checkVal({e.tag, "_y"}, oy, e.y);
      checkVal({e.tag, "_act"}, oa, e.act);
      checkVal({e.tag, "_exit"}, oe, e.ex);
    end
  endtask

  task automatic clearInputs();
    ifA.iLoad = 0; ifA.iLoadIdx = 0; ifA.iPosX = 0; ifA.iPosY = 0;
    ifA.iJump = 0; ifA.iJumpIdx = 0; ifA.iAuxX = 0; ifA.iAuxY = 0; ifA.iTick = 0;
    ifB.iLoad = 0; ifB.iLoadIdx = 0; ifB.iPosX = 0; ifB.iPosY = 0;
    ifB.iJump = 0; ifB.iJumpIdx = 0; ifB.iAuxX = 0; ifB.iAuxY = 0; ifB.iTick = 0;
`ifdef COLLISION_DETECT_EN
    ifA.iPlayerX = 0; ifA.iPlayerY = 0;
    ifB.iPlayerX = 0; ifB.iPlayerY = 0;
`endif
  endtask

  task automatic loadA(input int idx, input int x, input int y);
    ifA.iLoad = 1; ifA.iLoadIdx = 2'(idx); ifA.iPosX = 10'(x); ifA.iPosY = 9'(y);
  endtask

  task automatic jumpA(input int idx, input int x, input int y);
    ifA.iJump = 1; ifA.iJumpIdx = 2'(idx); ifA.iAuxX = 10'(x); ifA.iAuxY = 9'(y);
  endtask

  initial begin
    clearInputs();
    rst = 1;
    pushExp("rst_s0", 0, 0, 0, 0, 0, 0);
    pushExp("rst_s3", 0, 3, 0, 0, 0, 0);
    pushExp("rstB_s2", 1, 2, 0, 0, 0, 0);
    cycle();
    rst = 0;

    // Load slot0 then three frame ticks
    loadA(0, 100, 10);
    pushExp("load0", 0, 0, 100, 10, 4'b0001, 0);
    cycle();
    clearInputs();
    ifA.iTick = 1;
    for (int i = 1; i <= 3; i++) begin
      pushExp($sformatf("tick%0d", i), 0, 0, 100, 10 + i, 4'b0001, 0);
      cycle();
    end
    clearInputs();

    // Slot1 walks off the bottom edge
    loadA(1, 50, 478);
    pushExp("load1", 0, 1, 50, 478, 4'b0011, 0);
    pushExp("load1_s0hold", 0, 0, 100, 13, 4'b0011, 0);
    cycle();
    clearInputs();
    ifA.iTick = 1;
    pushExp("edge479", 0, 1, 50, 479, 4'b0011, 0);
    pushExp("edge479_s0", 0, 0, 100, 14, 4'b0011, 0);
    cycle();
    pushExp("exit1", 0, 1, 50, 479, 4'b0001, 4'b0010);
    pushExp("exit1_s0", 0, 0, 100, 15, 4'b0001, 4'b0010);
    cycle();
    ifA.iTick = 0;
    pushExp("exit1_gone", 0, 1, 50, 479, 4'b0001, 0);
    cycle();

    // Load and jump to slot2 together with a tick
    loadA(2, 1, 2);
    jumpA(2, 300, 200);
    ifA.iTick = 1;
    pushExp("ldjmp2", 0, 2, 300, 200, 4'b0101, 0);
    pushExp("ldjmp2_s0", 0, 0, 100, 16, 4'b0101, 0);
    pushExp("ldjmp2_s1", 0, 1, 50, 479, 4'b0101, 0);
    cycle();
    clearInputs();

    // Jump alone keeps the active flag
    jumpA(0, 5, 470);
    pushExp("jump0", 0, 0, 5, 470, 4'b0101, 0);
    cycle();
    clearInputs();

    // Load and jump to different slots in one cycle
    loadA(3, 7, 8);
    jumpA(2, 9, 9);
    pushExp("diff_s3", 0, 3, 7, 8, 4'b1101, 0);
    pushExp("diff_s2", 0, 2, 9, 9, 4'b1101, 0);
    cycle();
    clearInputs();

    // A jump during the would-be exit cycle suppresses the exit
    jumpA(0, 5, 479);
    pushExp("pre_sup", 0, 0, 5, 479, 4'b1101, 0);
    cycle();
    clearInputs();
    jumpA(0, 6, 479);
    ifA.iTick = 1;
    pushExp("sup_s0", 0, 0, 6, 479, 4'b1101, 0);
    pushExp("sup_s2", 0, 2, 9, 10, 4'b1101, 0);
    pushExp("sup_s3", 0, 3, 7, 9, 4'b1101, 0);
    cycle();
    clearInputs();

    // Off-screen load stays inactive and ignores ticks
    loadA(3, 20, 500);
    pushExp("offload", 0, 3, 20, 500, 4'b0101, 0);
    cycle();
    clearInputs();
    ifA.iTick = 1;
    pushExp("off_s3", 0, 3, 20, 500, 4'b0100, 4'b0001);
    pushExp("exit0", 0, 0, 6, 479, 4'b0100, 4'b0001);
    pushExp("off_s2", 0, 2, 9, 11, 4'b0100, 4'b0001);
    cycle();
    clearInputs();
    pushExp("exit0_gone", 0, 0, 6, 479, 4'b0100, 0);
    cycle();

    // Reset beats a simultaneous load
    rst = 1;
    loadA(0, 1, 1);
    for (int s = 0; s < 4; s++) pushExp($sformatf("rstld_s%0d", s), 0, s, 0, 0, 0, 0);
    cycle();
    rst = 0;
    clearInputs();

    // Out-of-range index on the 3-slot instance
    ifB.iLoad = 1; ifB.iLoadIdx = 2'd3; ifB.iPosX = 10'd11; ifB.iPosY = 9'd22;
    for (int s = 0; s < 3; s++) pushExp($sformatf("oor_s%0d", s), 1, s, 0, 0, 0, 0);
    cycle();
    ifB.iLoadIdx = 2'd2; ifB.iPosX = 10'd33; ifB.iPosY = 9'd44;
    pushExp("B_load2", 1, 2, 33, 44, 3'b100, 0);
    cycle();
    clearInputs();
    ifB.iTick = 1;
    pushExp("B_tick2", 1, 2, 33, 45, 3'b100, 0);
    pushExp("B_idle0", 1, 0, 0, 0, 3'b100, 0);
    cycle();
    clearInputs();

`ifdef COLLISION_DETECT_EN
    loadA(0, 200, 100);
    ifA.iPlayerX = 10'd210; ifA.iPlayerY = 9'd120;
    cycle();
    ifA.iLoad = 0;
    cycle();
    checkVal("coll_hit", int'(ifA.oCollision[0]), 1);
    ifA.iPlayerX = 10'd300;
    cycle();
    checkVal("coll_miss", int'(ifA.oCollision[0]), 0);
    clearInputs();
`endif

    cycle();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
